// File: rtl/replication_zoom_stream.sv
// Nearest-neighbour upscaler: each pixel repeated F times per line, each line emitted F times.
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | pass 0: accept input words, store to line buffer, emit sub-words
// REPLAY  | passes 1..F-1: emit sub-words from line buffer only
// FIN     | one-cycle done pulse
module replication_zoom_stream #(
    parameter int PIXEL_W        = 8,
    parameter int PIX_PER_WORD   = 4,
    parameter int MAX_LINE_WORDS = 40,
    parameter int LW_W           = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      zoom_mode,
    input  logic [LW_W-1:0]                 line_words,
    input  logic [15:0]                     frame_lines,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIXEL_W*PIX_PER_WORD-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PIXEL_W*PIX_PER_WORD-1:0] out_data,
    output logic                            out_eol,
    output logic                            out_eof,
    output logic                            busy,
    output logic                            done
);
    localparam int DW = PIXEL_W * PIX_PER_WORD;

    typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, FIN} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sh, sh_in, f_m1, sub, pass;
    logic [LW_W-1:0] lw, col;
    logic [15:0]     fl, line;
    logic            eof_pend;
    logic [DW-1:0]   line_buf [MAX_LINE_WORDS];

    logic            active, from_in, out_free, src_avail, load;
    logic            last_sub, last_col, last_pass, last_line, eol_nxt, eof_nxt;
    logic [DW-1:0]   src_word, mapped;

    always_comb begin
        case (zoom_mode)
            2'd1:    sh_in = 2'd1;
            2'd2:    sh_in = 2'd2;
            default: sh_in = 2'd0;
        endcase
        case (sh)
            2'd1:    f_m1 = 2'd1;
            2'd2:    f_m1 = 2'd3;
            default: f_m1 = 2'd0;
        endcase
    end

    assign last_sub  = (sub == f_m1);
    assign last_col  = (col == lw - LW_W'(1));
    assign last_pass = (pass == f_m1);
    assign last_line = (line == fl - 16'd1);
    assign eol_nxt   = last_sub && last_col;
    assign eof_nxt   = eol_nxt && last_pass && last_line;

    // Once the eof word is loaded nothing more is sourced; we only wait for its handshake.
    assign active    = ((state == CAPTURE) || (state == REPLAY)) && !eof_pend;
    assign from_in   = (state == CAPTURE) && (sub == 2'd0);
    assign out_free  = !out_valid || out_ready;
    assign src_avail = active && (from_in ? in_valid : 1'b1);
    assign load      = src_avail && out_free;
    assign in_ready  = active && from_in && out_free;
    assign src_word  = from_in ? in_data : line_buf[col];

    assign busy = (state == CAPTURE) || (state == REPLAY);
    assign done = (state == FIN);

    // Output pixel j of sub-word s takes source pixel (s*PIX_PER_WORD + j) / F.
    always_comb begin
        mapped = '0;
        for (int j = 0; j < PIX_PER_WORD; j++) begin
            for (int k = 0; k < PIX_PER_WORD; k++) begin
                if (k == ((int'(sub) * PIX_PER_WORD + j) >> sh))
                    mapped[j*PIXEL_W +: PIXEL_W] = src_word[k*PIXEL_W +: PIXEL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = ((line_words == '0) || (frame_lines == '0)) ? FIN : CAPTURE;
            end
            CAPTURE, REPLAY: begin
                if (eof_pend) begin
                    if (out_valid && out_ready && out_eof) state_nxt = FIN;
                end else if (load && eol_nxt) begin
                    if (!last_pass)      state_nxt = REPLAY;
                    else if (!last_line) state_nxt = CAPTURE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) line_buf[col] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= 2'd0;
            lw        <= '0;
            fl        <= '0;
            sub       <= 2'd0;
            col       <= '0;
            pass      <= 2'd0;
            line      <= '0;
            eof_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                sh       <= sh_in;
                lw       <= line_words;
                fl       <= frame_lines;
                sub      <= 2'd0;
                col      <= '0;
                pass     <= 2'd0;
                line     <= '0;
                eof_pend <= 1'b0;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mapped;
                out_eol   <= eol_nxt;
                out_eof   <= eof_nxt;
                if (eof_nxt) eof_pend <= 1'b1;
                if (!last_sub) begin
                    sub <= sub + 2'd1;
                end else begin
                    sub <= 2'd0;
                    if (!last_col) begin
                        col <= col + LW_W'(1);
                    end else begin
                        col <= '0;
                        if (!last_pass) begin
                            pass <= pass + 2'd1;
                        end else begin
                            pass <= 2'd0;
                            if (!last_line) line <= line + 16'd1;
                        end
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/replication_zoom_stream.md
Name: replication_zoom_stream

Overview:
- Streaming nearest-neighbour upscaler for the pixel datapath; successor to the fixed 2x horizontal pixel replicator.
- Runtime zoom factor F of 1, 2 or 4 in both axes: every pixel is repeated F times horizontally, and every line is emitted F times vertically.
- A single-line buffer replays each line; valid/ready handshakes are used on both sides.
- Sits between the frame/pixel source and the output packer.

Parameters:
- PIXEL_W, 8, bits per pixel.
- PIX_PER_WORD, 4, pixels per data word; must be a multiple of 4.
- MAX_LINE_WORDS, 40, input line buffer depth in words.
- LW_W, 6, width of line_words; must satisfy 2^LW_W > MAX_LINE_WORDS.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches zoom_mode, line_words and frame_lines when busy=0.
- zoom_mode  in  2  0=1x, 1=2x, 2=4x, 3=treated as 1x.
- line_words  in  LW_W  input words per line, valid range 1..MAX_LINE_WORDS.
- frame_lines  in  16  input lines per frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts in_data.
- in_data  in  PIXEL_W*PIX_PER_WORD  input pixels; pixel 0 occupies the LSBs.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  PIXEL_W*PIX_PER_WORD  output pixels.
- out_eol  out  1  last word of an output line.
- out_eof  out  1  last word of the frame (out_eol is also 1).
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters 0. Line buffer contents are don't-care. Reset mid-frame abandons the frame; no done pulse is produced.
- FSM states: IDLE, CAPTURE, REPLAY, FIN.
- IDLE -> CAPTURE on start, with busy=1.
- IDLE -> FIN on start when line_words=0 or frame_lines=0; no handshakes occur.
- start while busy=1 is ignored.
- Counters: sub (0..F-1, horizontal sub-word), col (0..line_words-1), pass (0..F-1), line (0..frame_lines-1).
- Output word mapping: for input word W and sub-word s, output pixel j = W pixel floor((s*PIX_PER_WORD + j)/F).
- Output register: loads whenever (!out_valid || out_ready) and a source word is available.
  - out_data, out_eol and out_eof hold stable while out_valid && !out_ready.
- CAPTURE (pass 0):
  - in_ready = (sub==0) && (!out_valid || out_ready).
  - On an input handshake, in_data is written to buffer[col] and sub-word 0 is formed from in_data. Latency: out_valid rises the cycle after the handshake.
  - Sub-words 1..F-1 are read from buffer[col].
  - After the last sub-word of the last col: go to REPLAY if F>1, otherwise advance the line.
- REPLAY (passes 1..F-1): in_ready=0; all words are read from buffer[col]. The buffer is a register array with asynchronous read.
- Throughput: with out_ready=1 and in_valid=1, one output word per cycle with no bubbles, including across pass and line boundaries.
- out_eol is set on sub=F-1 at col=line_words-1.
- out_eof is set on the out_eol word of the last pass of the last line.
- Line advance: pass=0, line+1, state CAPTURE. After the last line, wait for the eof word handshake, then go to FIN.
- FIN: done=1 for one cycle; busy=0 in that same cycle; next state IDLE.
- Words per frame: frame_lines*F * line_words*F.

Test Plan:
- Scenario 1 (2x basic):
  - Stimulus: mode=1, line_words=2, frame_lines=1; inputs 0x44332211 then 0x88776655; out_ready=1.
  - Required: outputs 0x22221111, 0x44443333, 0x66665555, 0x88887777, then the same four again.
  - out_eol on words 4 and 8; out_eof on word 8; done exactly one cycle after the final handshake.
- Scenario 2 (1x passthrough):
  - Stimulus: mode=0, line_words=3, frame_lines=2; 6 distinct input words.
  - Required: 6 identical output words in order; out_eol on words 3 and 6; out_eof on word 6.
- Scenario 3 (4x):
  - Stimulus: mode=2, line_words=1, frame_lines=1; input 0xDDCCBBAA.
  - Required: 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD, repeated 4 times (16 words); out_eol every 4th word; back-to-back output.
- Scenario 4 (backpressure):
  - Stimulus: scenario 1 with out_ready low for 5 cycles at word 3, then random toggling.
  - Required: out_data stable while stalled, in_ready=0 while stalled, same 8-word sequence as scenario 1.
- Scenario 5 (reset mid-frame):
  - Stimulus: assert reset during REPLAY.
  - Required: next cycle all outputs 0 and busy=0, no done pulse; a following start runs scenario 1 correctly.
- Scenario 6 (ignored start, reserved mode, empty frame):
  - Stimulus: start while busy; mode=3; start with line_words=0.
  - Required: start while busy has no effect; mode=3 behaves as 1x; line_words=0 gives done on the next cycle with no in_ready or out_valid.
